// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM state encoding and counter width helper.
package prog_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } state_t;
  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, memory write port and status out.
// slave  : loader side (rx_valid, rx_data, big_endian in; mem_*, busy, prog_rdy, err_timeout, chk_err out)
// master : stream source / memory side, the mirror image.
interface prog_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  big_endian;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  prog_rdy;
  logic                  err_timeout;
  logic                  chk_err;
  modport slave (
    input  rx_valid, rx_data, big_endian,
    output mem_we, mem_addr, mem_wdata, busy, prog_rdy, err_timeout, chk_err
  );
  modport master (
    output rx_valid, rx_data, big_endian,
    input  mem_we, mem_addr, mem_wdata, busy, prog_rdy, err_timeout, chk_err
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: packs BYTE_WIDTH symbols into DATA_WIDTH words, lane chosen per byte by big_endian.
// Ports: clk, arst_n (async, active-low), clr (drop partial word), in_valid/in_data/big_endian (byte in),
//        word (assembled word register), word_done (high with the byte that completes a word).
module word_assembler
  import prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  big_endian,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);
  localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = idx_bits(BPW);
  logic [IW-1:0] idx;
  logic [IW-1:0] lane;
  assign lane = big_endian ? IW'(BPW - 1) - idx : idx;
  assign word_done = in_valid && idx == IW'(BPW - 1);
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (in_valid) begin
      idx <= word_done ? '0 : idx + IW'(1);
      word[lane*BYTE_WIDTH +: BYTE_WIDTH] <= in_data;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (count header, data, optional checksum) and writes words to memory.
// Ports: clk, arst_n (async, active-low), bus (prog_loader_if.slave: rx stream in, mem write port and status out).
// Build option: define PROG_LOADER_CHECKSUM_EN to expect a trailing sum byte checked into chk_err.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int CNT_BYTES      = 2,
  parameter int ADDR_STEP      = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic          clk,
  input logic          arst_n,
  prog_loader_if.slave bus
);
  localparam int CW = CNT_BYTES * BYTE_WIDTH;
  localparam int HW = idx_bits(CNT_BYTES);
  localparam int TW = idx_bits(TIMEOUT_CYCLES);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  state_t                state, nxt, end_st;
  logic [CW-1:0]         n_cnt, n_next, word_idx;
  logic [HW-1:0]         hdr_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic start, last, hdr_done, counting, to_hit, asm_valid, word_done, trailer_ev, trailer_bad;
  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (start || to_hit),
    .in_valid  (asm_valid),
    .in_data   (bus.rx_data),
    .big_endian(bus.big_endian),
    .word      (word),
    .word_done (word_done)
  );
  assign last = word_idx == n_cnt - CW'(1);
  // Without a trailer, a byte arriving while the last word is written already opens the next frame.
  assign start = bus.rx_valid && (state == ST_IDLE || state == ST_DONE || (state == ST_WRITE && last && !CHK_EN));
  assign n_next = start ? CW'(bus.rx_data) : (n_cnt << BYTE_WIDTH) | CW'(bus.rx_data);
  assign hdr_done = start ? (CNT_BYTES == 1) : (state == ST_HDR && bus.rx_valid && hdr_cnt == HW'(CNT_BYTES - 1));
  assign counting = state inside {ST_HDR, ST_DATA, ST_CHK};
  assign to_hit = counting && !bus.rx_valid && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  // A byte during WRITE belongs to the next word unless the word being written is the last one.
  assign asm_valid = bus.rx_valid && (state == ST_DATA || (state == ST_WRITE && !last));
  assign trailer_ev = CHK_EN && bus.rx_valid && (state == ST_CHK || (state == ST_WRITE && last));
  assign end_st = CHK_EN ? ST_CHK : ST_DONE;
  always_comb begin
    nxt = state;
    if (to_hit) nxt = ST_IDLE;
    else if (hdr_done) nxt = n_next == '0 ? end_st : ST_DATA;
    else if (start) nxt = ST_HDR;
    else if (trailer_ev) nxt = trailer_bad ? ST_IDLE : ST_DONE;
    else if (state == ST_WRITE) nxt = last ? end_st : word_done ? ST_WRITE : ST_DATA;
    else if (state == ST_DATA && word_done) nxt = ST_WRITE;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_IDLE;
      n_cnt    <= '0;
      word_idx <= '0;
      hdr_cnt  <= '0;
      addr     <= '0;
      to_cnt   <= '0;
    end else begin
      state  <= nxt;
      to_cnt <= (bus.rx_valid || !counting) ? '0 : to_cnt + TW'(1);
      if (state == ST_WRITE) begin
        word_idx <= word_idx + CW'(1);
        addr     <= addr + ADDR_WIDTH'(ADDR_STEP);
      end
      if (start) begin
        n_cnt    <= n_next;
        hdr_cnt  <= HW'(1);
        word_idx <= '0;
        addr     <= '0;
      end else if (state == ST_HDR && bus.rx_valid) begin
        n_cnt   <= n_next;
        hdr_cnt <= hdr_cnt + HW'(1);
      end
    end
  end
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] sum;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sum <= '0;
    else if (start) sum <= '0;
    else if (asm_valid) sum <= sum + bus.rx_data;
  end
  assign trailer_bad = bus.rx_data != sum;
  assign bus.chk_err = trailer_ev && trailer_bad;
`else
  assign trailer_bad = 1'b0;
  assign bus.chk_err = 1'b0;
`endif
  assign bus.mem_we      = state == ST_WRITE;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = word;
  assign bus.busy        = state inside {ST_HDR, ST_DATA, ST_WRITE, ST_CHK};
  assign bus.prog_rdy    = state == ST_DONE && !bus.rx_valid;
  assign bus.err_timeout = to_hit;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, received symbol width; DATA_WIDTH SHALL be an integer multiple, giving BPW = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-004 SHALL have parameter CNT_BYTES, default 2, header length in bytes carrying word count N.
REQ-005 SHALL have parameter ADDR_STEP, default 4, address increment per word.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle-gap limit inside a frame.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 arst_n  in  1  reset, asynchronous, active-low.
REQ-009 rx_valid  in  1  one-cycle strobe, byte available.
REQ-010 rx_data  in  BYTE_WIDTH  received byte, valid with rx_valid.
REQ-011 big_endian  in  1  1: first data byte goes to MSBs; 0: to LSBs; sampled per byte.
REQ-012 mem_we  out  1  one-cycle word write strobe.
REQ-013 mem_addr  out  ADDR_WIDTH  write address.
REQ-014 mem_wdata  out  DATA_WIDTH  assembled word.
REQ-015 busy  out  1  high while a frame is in progress.
REQ-016 prog_rdy  out  1  high after a good frame, until the next frame starts.
REQ-017 err_timeout  out  1  one-cycle pulse on frame abort.
REQ-018 chk_err  out  1  one-cycle pulse on checksum mismatch; constant 0 without macro.

Function
REQ-019 States SHALL be IDLE, HDR, DATA, WRITE, CHK, DONE.
REQ-020 IDLE/DONE + rx_valid: byte SHALL be the MSB of N; go HDR (or straight to DATA/DONE if CNT_BYTES=1); prog_rdy SHALL drop in the same cycle.
REQ-021 HDR SHALL shift in bytes MSB-first until CNT_BYTES received; N=0 SHALL go directly to DONE (CHK with macro).
REQ-022 DATA SHALL place byte k (0..BPW-1) at lane BPW-1-k if big_endian, else lane k.
REQ-023 After BPW-th byte, WRITE SHALL assert mem_we for exactly one cycle, with mem_wdata and mem_addr stable in that cycle.
REQ-024 mem_addr SHALL be word_index*ADDR_STEP, modulo 2^ADDR_WIDTH (wrap, no error); first word at 0.
REQ-025 rx_valid during WRITE SHALL be accepted as byte 0 of the next word; no byte lost.
REQ-026 After word N-1 written, the FSM SHALL go to DONE (or CHK with macro).
REQ-027 Timeout counter SHALL reset on every rx_valid and count in HDR/DATA/CHK; on reaching TIMEOUT_CYCLES: pulse err_timeout, discard partial word, go IDLE, prog_rdy stays 0.
REQ-028 busy SHALL be 1 in HDR, DATA, WRITE, CHK.
REQ-029 Word count counter SHALL be CNT_BYTES*BYTE_WIDTH bits wide; no saturation.

Reset
REQ-030 Reset SHALL force IDLE, all counters and accumulators 0, all outputs 0, effective immediately even mid-frame.

Configuration
REQ-031 With PROG_LOADER_CHECKSUM_EN defined: after the last word, CHK SHALL take one trailer byte; if it differs from the mod-2^BYTE_WIDTH sum of all data bytes, pulse chk_err and return IDLE, else go DONE.
REQ-032 Without PROG_LOADER_CHECKSUM_EN: no CHK state, no trailer byte, chk_err tied 0.

Structure
REQ-033 State enum and width helpers SHALL live in package prog_loader_pkg.
REQ-034 Byte-to-word lane packing SHALL be sub-module word_assembler (BPW counter, endian lane select, word-complete strobe).

Verification
REQ-035 Header 00 02, big_endian=1, bytes 11 22 33 44 55 66 77 88 -> writes 0x11223344@0, 0x55667788@4, then prog_rdy=1.
REQ-036 Same with big_endian=0 -> 0x44332211@0, 0x88776655@4.
REQ-037 Header 00 00 -> no mem_we, prog_rdy=1 (with macro after trailer 00).
REQ-038 ADDR_WIDTH=4, N=5 -> addresses 0,4,8,12,0.
REQ-039 Header 00 01, two bytes then TIMEOUT_CYCLES idle -> one err_timeout pulse, no mem_we, IDLE; next frame loads correctly.
REQ-040 With macro: N=1, bytes 01 02 03 04, trailer 0A -> prog_rdy=1; trailer 0B -> chk_err pulse, prog_rdy=0.
